twiddle_gen: RTL and testbench

Sequenced twiddle-factor generator for the radix-2 DIT FFT core, sitting between the stage controller and the butterfly datapath. It stores only a quarter-wave cosine table (NFFT/4+1 entries) and folds addresses to produce every W_N^k = cos(2πk/N) − j·sin(2πk/N) for k in 0..NFFT/2−1. On a start command it emits the full per-stage twiddle sequence, one per butterfly, over a valid/ready stream. A mode bit selects conjugated twiddles for inverse FFT.

---
 rtl/twiddle_gen.sv | 189 ++++++++++++++++++
 tb/tb_twiddle_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
// Purpose : sequenced radix-2 DIT FFT twiddle generator; quarter-wave cosine table with address folding.
// Latency : 2 cycles from accepted i_start to first o_valid, then one twiddle per cycle while i_ready=1.
// Backpr. : o_valid & ~i_ready stalls the butterfly counter and both pipeline stages; outputs hold.
// Ports   : i_clk/i_rst_n (sync active-low) | i_start,i_stage,i_inv command (taken only when o_busy=0)
//           o_busy high from accepted start to last accepted output | o_valid/i_ready output stream
//           o_re/o_im signed Q(W-FRAC-1).FRAC twiddle, o_k twiddle index, o_last on final output.
module twiddle_gen #(
   parameter int NFFT    = 32,
   parameter int W       = 16,
   parameter int FRAC    = 14,
   parameter     MEMFILE = "tw_cos.mem"
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   input  logic                            i_start,
   input  logic [$clog2(NFFT)-1:0]         i_stage,
   input  logic                            i_inv,
   output logic                            o_busy,
   output logic                            o_valid,
   input  logic                            i_ready,
   output logic signed [W-1:0]             o_re,
   output logic signed [W-1:0]             o_im,
   output logic [$clog2(NFFT/2)-1:0]       o_k,
   output logic                            o_last
);

   localparam int LOG2N = $clog2(NFFT);
   localparam int KW    = LOG2N - 1;           // width of j and k
   localparam int Q     = NFFT / 4;
   localparam int AW    = $clog2(Q + 1);
   localparam longint TWO_PI_S = 64'sd1686629713;  // 2*pi scaled by 2^28

   // Table contents equal the MEMFILE image: C[i] = round(cos(2*pi*i/NFFT) * 2^FRAC).
   // Evaluated at elaboration with a fixed-point Taylor series (2^28 scale) so no file is needed.
   function automatic int cos_fix(input int idx);
      longint s, x, x2, term, sum;
      s    = longint'(1) << 28;
      x    = (TWO_PI_S * longint'(idx) + longint'(NFFT / 2)) / longint'(NFFT);
      x2   = (x * x + s / 2) >>> 28;
      term = s;
      sum  = s;
      for (int n = 1; n <= 10; n++) begin
         term = -(term * x2) / (s * longint'((2 * n - 1) * (2 * n)));
         sum  = sum + term;
      end
      return int'((sum * (longint'(1) << FRAC) + s / 2) >>> 28);
   endfunction

   logic signed [W-1:0] ctab [0:Q];
   for (genvar g = 0; g <= Q; g++) begin : g_tab
      assign ctab[g] = W'(cos_fix(g));
   end

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t state_q, state_d;

   logic [LOG2N-1:0]    stage_q;
   logic                inv_q;
   logic [KW-1:0]       j_q;
   logic                iss_q;       // still issuing j values into stage 1
   // stage 1
   logic                v1_q;
   logic [KW-1:0]       k1_q;
   logic [AW-1:0]       ra1_q, ia1_q;
   logic                nre1_q, nim1_q, last1_q;
   // stage 2 (output registers)
   logic                vld_q, last_q;
   logic signed [W-1:0] re_q, im_q;
   logic [KW-1:0]       k_q;

   logic                adv, start_acc, fin;
   logic [LOG2N-1:0]    stage_in, shamt;
   logic [KW-1:0]       jmask, kcalc;
   logic [AW-1:0]       ra_d, ia_d;
   logic                nre_d;
   int                  ki;
   logic signed [W-1:0] cre, cim, re_d, im_d;

   assign adv       = ~vld_q | i_ready;
   assign start_acc = (state_q == S_IDLE) & i_start;
   assign fin       = vld_q & i_ready & last_q;
   assign stage_in  = (i_stage > LOG2N'(KW)) ? LOG2N'(KW) : i_stage;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_start) state_d = S_RUN;
         S_RUN:   if (fin)     state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state_q == S_RUN);
   end

   // k = (j mod 2^s) * 2^(KW-s); s never exceeds KW after clamping
   always_comb begin
      jmask = ~({KW{1'b1}} << stage_q);
      shamt = LOG2N'(KW) - stage_q;
      kcalc = (j_q & jmask) << shamt;
   end

   // Fold k onto the quarter table: first quadrant reads C[k] / C[Q-k],
   // second quadrant reads C[2Q-k] / C[k-Q] with the real part negated.
   always_comb begin
      ki = int'(kcalc);
      if (ki <= Q) begin
         ra_d  = AW'(ki);
         ia_d  = AW'(Q - ki);
         nre_d = 1'b0;
      end else begin
         ra_d  = AW'(2 * Q - ki);
         ia_d  = AW'(ki - Q);
         nre_d = 1'b1;
      end
   end

   always_comb begin
      cre  = ctab[ra1_q];
      cim  = ctab[ia1_q];
      re_d = nre1_q ? -cre : cre;
      im_d = nim1_q ? -cim : cim;
   end

   // ---------------- counter and pipeline ----------------
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         stage_q <= '0;
         inv_q   <= 1'b0;
         j_q     <= '0;
         iss_q   <= 1'b0;
         v1_q    <= 1'b0;
         k1_q    <= '0;
         ra1_q   <= '0;
         ia1_q   <= '0;
         nre1_q  <= 1'b0;
         nim1_q  <= 1'b0;
         last1_q <= 1'b0;
         vld_q   <= 1'b0;
         last_q  <= 1'b0;
         re_q    <= '0;
         im_q    <= '0;
         k_q     <= '0;
      end else begin
         if (start_acc) begin
            stage_q <= stage_in;
            inv_q   <= i_inv;
            j_q     <= '0;
            iss_q   <= 1'b1;
         end else if (adv && iss_q) begin
            j_q <= j_q + 1'b1;
            if (&j_q) iss_q <= 1'b0;
         end

         if (adv) begin
            v1_q <= iss_q;
            if (iss_q) begin
               k1_q    <= kcalc;
               ra1_q   <= ra_d;
               ia1_q   <= ia_d;
               nre1_q  <= nre_d;
               nim1_q  <= ~inv_q;   // forward twiddle has -sin; inverse conjugates it
               last1_q <= &j_q;
            end
            vld_q <= v1_q;
            if (v1_q) begin
               re_q   <= re_d;
               im_q   <= im_d;
               k_q    <= k1_q;
               last_q <= last1_q;
            end
         end
      end
   end

   assign o_valid = vld_q;
   assign o_re    = re_q;
   assign o_im    = im_q;
   assign o_k     = k_q;
   assign o_last  = vld_q & last_q;

endmodule

// File: tb/tb_twiddle_gen.sv
module tb_twiddle_gen;
   localparam int NFFT = 32;
   localparam int W    = 16;
   localparam int FRAC = 14;

   logic              i_clk = 1'b0;
   logic              i_rst_n, i_start, i_inv, i_ready;
   logic [4:0]        i_stage;
   logic              o_busy, o_valid, o_last;
   logic signed [15:0] o_re, o_im;
   logic [3:0]        o_k;

   always #5 i_clk = ~i_clk;

   twiddle_gen #(.NFFT(NFFT), .W(W), .FRAC(FRAC), .MEMFILE("tw_cos.mem")) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_start (i_start),
      .i_stage (i_stage),
      .i_inv   (i_inv),
      .o_busy  (o_busy),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_re    (o_re),
      .o_im    (o_im),
      .o_k     (o_k),
      .o_last  (o_last)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      int k;
      int re;
      int im;
      bit last;
   } exp_t;
   exp_t sbq[$];
   exp_t e;

   // hand-computed forward twiddles W_32^k in Q1.14
   int re_tab [16] = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196,
                       0, -3196, -6270, -9102, -11585, -13623, -15137, -16069};
   int im_tab [16] = '{0, -3196, -6270, -9102, -11585, -13623, -15137, -16069,
                       -16384, -16069, -15137, -13623, -11585, -9102, -6270, -3196};

   task automatic check(input string name, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   // ---------------- monitor ----------------
   bit                 stalled = 1'b0;
   logic signed [15:0] s_re, s_im;
   logic [3:0]         s_k;
   logic               s_last;

   always @(negedge i_clk) begin
      if (i_rst_n) begin
         if (stalled) begin
            check("stall_valid", int'(o_valid), 1);
            check("stall_k", int'(o_k), int'(s_k));
            check("stall_re", int'(o_re), int'(s_re));
            check("stall_im", int'(o_im), int'(s_im));
            check("stall_last", int'(o_last), int'(s_last));
         end
         stalled = 1'b0;
         if (o_valid && i_ready) begin
            if (sbq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: got k=%0d expected none", o_k);
            end else begin
               e = sbq.pop_front();
               check("out_k", int'(o_k), e.k);
               check("out_re", int'(o_re), e.re);
               check("out_im", int'(o_im), e.im);
               check("out_last", int'(o_last), int'(e.last));
            end
         end else if (o_valid) begin
            stalled = 1'b1;
            s_re    = o_re;
            s_im    = o_im;
            s_k     = o_k;
            s_last  = o_last;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic push_seq(input int stg, input int inv);
      exp_t x;
      int   s, k;
      s = (stg > 4) ? 4 : stg;
      for (int j = 0; j < 16; j++) begin
         k      = (j % (1 << s)) * (16 >> s);
         x.k    = k;
         x.re   = re_tab[k];
         x.im   = (inv != 0) ? -im_tab[k] : im_tab[k];
         x.last = (j == 15);
         sbq.push_back(x);
      end
   endtask

   task automatic run_seq(input int stg, input int inv, input int rmode,
                          input bit chk_lat, input bit ign);
      int cyc;
      bit done;
      push_seq(stg, inv);
      i_stage = 5'(stg);
      i_inv   = (inv != 0);
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (chk_lat) begin
         check("busy_after_start", int'(o_busy), 1);
         check("valid_lat0", int'(o_valid), 0);
         @(posedge i_clk); #1;
         check("valid_lat1", int'(o_valid), 0);
         @(posedge i_clk); #1;
         check("valid_lat2", int'(o_valid), 1);
         check("first_k", int'(o_k), 0);
      end
      cyc  = 0;
      done = 1'b0;
      while (cyc < 400 && !done) begin
         i_ready = (rmode == 1) ? (cyc % 3 == 0) : 1'b1;
         if (ign && cyc == 4) begin
            i_start = 1'b1;
            i_stage = 5'd0;
            i_inv   = 1'b1;
         end else begin
            i_start = 1'b0;
         end
         @(posedge i_clk); #1;
         cyc++;
         if (sbq.size() == 0) done = 1'b1;
      end
      i_start = 1'b0;
      i_ready = 1'b1;
      i_inv   = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL seq_timeout: got %0d outputs left expected 0", sbq.size());
         sbq.delete();
      end else begin
         check("busy_fall", int'(o_busy), 0);
         check("valid_fall", int'(o_valid), 0);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, int'(o_busy), 0);
      check({tag, "_valid"}, int'(o_valid), 0);
      check({tag, "_last"}, int'(o_last), 0);
      check({tag, "_re"}, int'(o_re), 0);
      check({tag, "_im"}, int'(o_im), 0);
      check({tag, "_k"}, int'(o_k), 0);
   endtask

   task automatic reset_mid();
      int  cyc;
      bit  hit;
      push_seq(4, 0);
      i_stage = 5'd4;
      i_inv   = 1'b0;
      i_ready = 1'b1;
      i_start = 1'b1;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      hit = 1'b0;
      cyc = 0;
      while (cyc < 100 && !hit) begin
         @(negedge i_clk);
         cyc++;
         if (o_valid && o_k == 4'd6) hit = 1'b1;
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL midreset_wait: got no k=6 expected k=6 output");
      end
      i_rst_n = 1'b0;
      @(posedge i_clk); #1;
      check_zero("midreset");
      i_rst_n = 1'b1;
      sbq.delete();
      @(posedge i_clk); #1;
      check("midreset_idle_valid", int'(o_valid), 0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_start = 1'b0;
      i_stage = 5'd0;
      i_inv   = 1'b0;
      i_ready = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      check_zero("reset");
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;

      run_seq(4, 0, 0, 1'b1, 1'b0);   // full forward sequence with latency check
      run_seq(0, 0, 0, 1'b0, 1'b0);   // all k=0
      run_seq(1, 0, 0, 1'b0, 1'b0);   // k alternates 0,8
      run_seq(4, 1, 0, 1'b0, 1'b0);   // inverse: conjugated imag
      run_seq(4, 0, 1, 1'b0, 1'b0);   // ready pattern 1,0,0
      run_seq(4, 0, 0, 1'b0, 1'b1);   // start while busy ignored
      run_seq(7, 0, 0, 1'b0, 1'b0);   // out-of-range stage clamps to 4
      reset_mid();
      run_seq(4, 0, 0, 1'b1, 1'b0);   // clean sequence after mid-run reset

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule
